// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 64-bit ALU: decodes the ALU control, resolves
// EX/MEM and MEM/WB forwarding, and holds the operands in a one-entry valid/ready register.
module alu_issue_stage #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [1:0]          aluOp,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                aluSrc,
    input  logic [REG_BITS-1:0] rs1,
    input  logic [REG_BITS-1:0] rs2,
    input  logic [REG_BITS-1:0] rd,
    input  logic [WIDTH-1:0]    rs1Data,
    input  logic [WIDTH-1:0]    rs2Data,
    input  logic [WIDTH-1:0]    immediate,
    input  logic                exMemRegWrite,
    input  logic                memWbRegWrite,
    input  logic [REG_BITS-1:0] exMemRd,
    input  logic [REG_BITS-1:0] memWbRd,
    input  logic [WIDTH-1:0]    exMemResult,
    input  logic [WIDTH-1:0]    memWbResult,
    input  logic                flush,
    output logic                outValid,
    input  logic                outReady,
    output logic [WIDTH-1:0]    input1,
    output logic [WIDTH-1:0]    input2,
    output logic [3:0]          aluControl,
    output logic [WIDTH-1:0]    storeData,
    output logic [REG_BITS-1:0] rdOut,
    output logic                illegalOp
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_BAD = 4'b1111
    } alu_ctrl_e;

    // Youngest matching producer wins; x0 is hardwired to zero and never forwarded.
    function automatic logic [WIDTH-1:0] forward(
        input logic [REG_BITS-1:0] rs,
        input logic [WIDTH-1:0]    rf_data,
        input logic                ex_we,
        input logic [REG_BITS-1:0] ex_rd,
        input logic [WIDTH-1:0]    ex_res,
        input logic                wb_we,
        input logic [REG_BITS-1:0] wb_rd,
        input logic [WIDTH-1:0]    wb_res
    );
        if (rs == '0)
            return rf_data;
        else if (ex_we && (ex_rd == rs))
            return ex_res;
        else if (wb_we && (wb_rd == rs))
            return wb_res;
        else
            return rf_data;
    endfunction

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      input1_q, input2_q, store_q;
    alu_ctrl_e             ctrl_q;
    logic [REG_BITS-1:0]   rd_q;
    logic                  illegal_q;

    alu_ctrl_e             ctrl_d;
    logic                  illegal_d;
    logic [WIDTH-1:0]      fwd1, fwd2;
    logic                  capture;

    // Control decode
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements can infer a latch.
    always_comb begin
        ctrl_d    = ALU_BAD;
        illegal_d = 1'b0;
        unique case (aluOp)
            2'b00: ctrl_d = ALU_ADD;
            2'b01: ctrl_d = ALU_SUB;
            2'b10: begin
                unique case ({funct7b5, funct3})
                    4'b0_000: ctrl_d = ALU_ADD;
                    4'b1_000: ctrl_d = ALU_SUB;
                    4'b0_111: ctrl_d = ALU_AND;
                    4'b0_110: ctrl_d = ALU_OR;
                    default: begin
                        ctrl_d    = ALU_BAD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_d    = ALU_BAD;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        fwd1 = forward(rs1, rs1Data, exMemRegWrite, exMemRd, exMemResult,
                       memWbRegWrite, memWbRd, memWbResult);
        fwd2 = forward(rs2, rs2Data, exMemRegWrite, exMemRd, exMemResult,
                       memWbRegWrite, memWbRd, memWbResult);
    end

    assign inReady = (state_q == EMPTY) || outReady;
    assign capture = inValid && inReady && !flush;

    // Flush beats capture, capture beats drain (back-to-back with no bubble).
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (capture)
            state_d = FULL;
        else if ((state_q == FULL) && outReady)
            state_d = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // NOTE: the operand registers are reset too, because the ALU-facing outputs
    // must read zero after reset rather than whatever was last captured.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            input1_q  <= '0;
            input2_q  <= '0;
            store_q   <= '0;
            ctrl_q    <= ALU_AND;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else if (capture) begin
            input1_q  <= fwd1;
            input2_q  <= aluSrc ? immediate : fwd2;
            store_q   <= fwd2;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd;
            illegal_q <= illegal_d;
        end
    end

    assign outValid   = (state_q == FULL);
    assign input1     = input1_q;
    assign input2     = input2_q;
    assign storeData  = store_q;
    assign aluControl = ctrl_q;
    assign rdOut      = rd_q;
    assign illegalOp  = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, back-pressure, flush and async reset.
module tb_alu_issue_stage;

    localparam int WIDTH    = 64;
    localparam int REG_BITS = 5;

    logic                clock = 1'b0;
    logic                resetN;
    logic                inValid, inReady;
    logic [1:0]          aluOp;
    logic [2:0]          funct3;
    logic                funct7b5, aluSrc;
    logic [REG_BITS-1:0] rs1, rs2, rd;
    logic [WIDTH-1:0]    rs1Data, rs2Data, immediate;
    logic                exMemRegWrite, memWbRegWrite;
    logic [REG_BITS-1:0] exMemRd, memWbRd;
    logic [WIDTH-1:0]    exMemResult, memWbResult;
    logic                flush, outValid, outReady;
    logic [WIDTH-1:0]    input1, input2, storeData;
    logic [3:0]          aluControl;
    logic [REG_BITS-1:0] rdOut;
    logic                illegalOp;

    int total = 0;
    int passed = 0;

    alu_issue_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .aluOp(aluOp), .funct3(funct3), .funct7b5(funct7b5), .aluSrc(aluSrc),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .immediate(immediate),
        .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite),
        .exMemRd(exMemRd), .memWbRd(memWbRd),
        .exMemResult(exMemResult), .memWbResult(memWbResult),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .input1(input1), .input2(input2), .aluControl(aluControl),
        .storeData(storeData), .rdOut(rdOut), .illegalOp(illegalOp)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic f7, input logic [2:0] f3,
                          input logic [63:0] d1, input logic [63:0] d2);
        aluOp    = op;
        funct7b5 = f7;
        funct3   = f3;
        rs1Data  = d1;
        rs2Data  = d2;
    endtask

    initial begin
        resetN = 1'b0; inValid = 1'b0; aluOp = 2'b10; funct3 = 3'b000; funct7b5 = 1'b0;
        aluSrc = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        rs1Data = '0; rs2Data = '0; immediate = '0;
        exMemRegWrite = 1'b0; memWbRegWrite = 1'b0; exMemRd = '0; memWbRd = '0;
        exMemResult = '0; memWbResult = '0; flush = 1'b0; outReady = 1'b1;

        // Reset state
        #12;
        check("rst_outValid", outValid, 0);
        check("rst_inReady", inReady, 1);
        check("rst_aluControl", aluControl, 0);
        check("rst_input1", input1, 0);
        @(negedge clock);
        resetN = 1'b1;

        // R-type ADD, no hazards
        inValid = 1'b1;
        set_op(2'b10, 1'b0, 3'b000, 64'd123, 64'd321);
        tick();
        check("add_outValid", outValid, 1);
        check("add_input1", input1, 123);
        check("add_input2", input2, 321);
        check("add_ctrl", aluControl, 4'b0010);
        check("add_rdOut", rdOut, 3);
        check("add_illegal", illegalOp, 0);

        // Double forwarding: EX/MEM has priority
        rs1 = 5'd5; rs2 = 5'd5;
        exMemRegWrite = 1'b1; exMemRd = 5'd5; exMemResult = 64'd750;
        memWbRegWrite = 1'b1; memWbRd = 5'd5; memWbResult = 64'd99;
        tick();
        check("fwd_ex_in1", input1, 750);
        check("fwd_ex_in2", input2, 750);
        check("fwd_ex_store", storeData, 750);

        exMemRegWrite = 1'b0;
        tick();
        check("fwd_wb_in1", input1, 99);

        rs1 = 5'd0; exMemRegWrite = 1'b1; exMemRd = 5'd0; rs1Data = 64'd11;
        tick();
        check("fwd_x0_in1", input1, 11);
        check("fwd_x0_in2_wb", input2, 99);

        // Back-pressure: SUB then AND held off for 3 cycles
        exMemRegWrite = 1'b0; memWbRegWrite = 1'b0; rs1 = 5'd1; rs2 = 5'd2;
        set_op(2'b10, 1'b1, 3'b000, 64'd128, 64'd64);
        tick();
        check("sub_ctrl", aluControl, 4'b0110);
        outReady = 1'b0;
        set_op(2'b10, 1'b0, 3'b111, 64'hFFFF_FFFF, 64'h0101_0101);
        #1;
        check("bp_inReady_comb", inReady, 0);
        for (int i = 0; i < 3; i++) begin
            // Forwarding changes while held must not disturb the entry.
            exMemRegWrite = 1'b1; exMemRd = 5'd1; exMemResult = 64'd555;
            tick();
            check("bp_hold_valid", outValid, 1);
            check("bp_hold_inReady", inReady, 0);
            check("bp_hold_ctrl", aluControl, 4'b0110);
            check("bp_hold_in1", input1, 128);
            check("bp_hold_in2", input2, 64);
        end
        exMemRegWrite = 1'b0;
        outReady = 1'b1;
        #1;
        check("bp_release_inReady", inReady, 1);
        tick();
        check("bp_and_valid", outValid, 1);
        check("bp_and_ctrl", aluControl, 4'b0000);
        check("bp_and_in1", input1, 64'hFFFF_FFFF);
        check("bp_and_in2", input2, 64'h0101_0101);

        // OR decode
        set_op(2'b10, 1'b0, 3'b110, 64'd1, 64'd2);
        tick();
        check("or_ctrl", aluControl, 4'b0001);

        // Immediate and store operands
        set_op(2'b00, 1'b0, 3'b000, 64'd7, 64'hAAAA);
        aluSrc = 1'b1; immediate = 64'h10;
        tick();
        check("imm_ctrl", aluControl, 4'b0010);
        check("imm_in2", input2, 64'h10);
        check("imm_store", storeData, 64'hAAAA);

        aluOp = 2'b01;
        tick();
        check("branch_ctrl", aluControl, 4'b0110);

        // Illegal ops still issue
        aluSrc = 1'b0;
        set_op(2'b10, 1'b0, 3'b100, 64'd1, 64'd2);
        tick();
        check("ill_ctrl", aluControl, 4'b1111);
        check("ill_flag", illegalOp, 1);
        check("ill_valid", outValid, 1);
        aluOp = 2'b11;
        tick();
        check("ill11_flag", illegalOp, 1);

        // Flush drops the incoming entry and keeps data outputs
        flush = 1'b1;
        set_op(2'b10, 1'b0, 3'b000, 64'd40, 64'd2);
        tick();
        check("flush_valid", outValid, 0);
        check("flush_ctrl_kept", aluControl, 4'b1111);
        flush = 1'b0; inValid = 1'b0;
        tick();
        check("flush_idle_valid", outValid, 0);

        // Drain without new capture
        inValid = 1'b1;
        tick();
        check("cap_valid", outValid, 1);
        inValid = 1'b0;
        tick();
        check("drain_valid", outValid, 0);

        // Asynchronous reset while FULL
        inValid = 1'b1;
        set_op(2'b10, 1'b1, 3'b000, 64'd900, 64'd100);
        tick();
        check("pre_rst_valid", outValid, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_valid", outValid, 0);
        check("arst_in1", input1, 0);
        check("arst_in2", input2, 0);
        check("arst_store", storeData, 0);
        check("arst_ctrl", aluControl, 0);
        check("arst_illegal", illegalOp, 0);
        check("arst_inReady", inReady, 1);
        @(negedge clock);
        resetN = 1'b1;
        set_op(2'b10, 1'b0, 3'b000, 64'd5, 64'd6);
        tick();
        check("post_rst_valid", outValid, 1);
        check("post_rst_in1", input1, 5);
        check("post_rst_ctrl", aluControl, 4'b0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
